// File: rtl/imem_if.sv
// Instruction memory request/response channel: one request outstanding,
// variable latency between grant and response.
interface imem_if;
  logic        req;
  logic [29:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the word PC, fetches over a req/gnt/rvalid channel and fills
// the IF/ID register; handles ID redirects (no delay slot) and stall holds.
module fetch_stage #(
  parameter logic [29:0] RESET_PC  = 30'h0000_0C00,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         jpc_avail,
  input  logic [29:0]  jpc,
  imem_if.master       imem,
  output logic [61:0]  id_data,
  output logic         id_valid,
  output logic [29:0]  fetch_pc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [29:0] pc;
  logic [29:0] fetched_pcp1;
  logic [31:0] hold_instr;
  logic        kill;

  logic        redir;
  logic [29:0] addr;
  logic        resp;
  logic        fresh;
  logic        req;
  logic        granted;
  logic [29:0] addr_p1;

  // A response in WAIT is only usable when no redirect has made it stale.
  always_comb begin
    redir   = jpc_avail & ~stall;
    addr    = redir ? jpc : pc;
    addr_p1 = 30'(addr + 30'd1);
    resp    = (state == S_WAIT) && imem.rvalid;
    fresh   = resp && !kill;
    req     = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  req = 1'b1;
        S_WAIT:  req = fresh && !stall;
        default: req = 1'b0;
      endcase
    end
    granted = req && imem.gnt;
  end

  assign imem.req  = req;
  assign imem.addr = addr;
  assign fetch_pc  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      fetched_pcp1 <= '0;
      hold_instr   <= '0;
      kill         <= 1'b0;
      id_valid     <= 1'b0;
      id_data      <= '0;
    end else begin
      if (granted) begin
        pc           <= addr_p1;
        fetched_pcp1 <= addr_p1;
      end else if (redir) begin
        pc <= jpc;
      end

      case (state)
        S_IDLE: begin
          if (granted) state <= S_WAIT;
        end
        S_WAIT: begin
          if (resp) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_IDLE;
            end else if (stall) begin
              hold_instr <= imem.rdata;
              state      <= S_HOLD;
            end else begin
              state <= granted ? S_WAIT : S_IDLE;
            end
          end else if (redir) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          // Leaving on redirect discards the buffer: the IF/ID path below bubbles.
          if (!stall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (!stall) begin
        if (redir) begin
          id_data  <= {pc, NOP_INSTR};
          id_valid <= 1'b0;
        end else if (fresh) begin
          id_data  <= {fetched_pcp1, imem.rdata};
          id_valid <= 1'b1;
        end else if (state == S_HOLD) begin
          id_data  <= {fetched_pcp1, hold_instr};
          id_valid <= 1'b1;
        end else begin
          id_data  <= {pc, NOP_INSTR};
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a responding instruction memory plus a
// program-order scoreboard, directed scenarios and a randomized run.
module tb_fetch_stage;

  localparam logic [29:0] RESET_PC  = 30'h0000_0C00;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jpc_avail;
  logic [29:0] jpc;
  logic [61:0] id_data;
  logic        id_valid;
  logic [29:0] fetch_pc;

  imem_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jpc_avail(jpc_avail), .jpc(jpc),
    .imem(imem), .id_data(id_data), .id_valid(id_valid), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model: one response pending, delivered lat cycles after its grant.
  logic        mem_pend;
  logic [29:0] mem_addr;
  int          mem_cnt;
  int          lat_cfg;
  logic [31:0] prog [logic [29:0]];

  // Scoreboard: the word address of the next instruction in program order.
  logic [29:0] exp_next;
  int          delivered;

  logic        s_req;
  logic [29:0] s_addr;
  logic [61:0] pre_data;
  logic        pre_valid;

  function automatic logic [31:0] rd(input logic [29:0] a);
    if (prog.exists(a)) return prog[a];
    return {a, 2'b01} ^ 32'hA5C3_0000;
  endfunction

  task automatic step(input logic r, input logic st, input logic ja,
                      input logic [29:0] jp, input logic g);
    logic rv_now;
    logic granted;
    logic redir;
    logic [61:0] want;
    @(negedge clk);
    rst       = r;
    stall     = st;
    jpc_avail = ja;
    jpc       = jp;
    rv_now       = mem_pend && (mem_cnt == 1);
    imem.rvalid  = rv_now;
    imem.rdata   = rv_now ? rd(mem_addr) : 32'hDEAD_BEEF;
    imem.gnt     = g && (!mem_pend || rv_now);
    #1;
    s_req     = imem.req;
    s_addr    = imem.addr;
    pre_data  = id_data;
    pre_valid = id_valid;
    granted   = s_req && imem.gnt;
    redir     = ja && !st;
    if (r) begin
      total++;
      if (s_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL req_in_reset: got %b want 0", s_req);
      end
    end
    @(posedge clk);
    #1;
    if (rv_now) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      mem_pend = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = lat_cfg;
    end
    total++;
    if (r) begin
      exp_next = RESET_PC;
      if (id_valid !== 1'b0 || id_data !== 62'd0 || fetch_pc !== RESET_PC) begin
        bad++;
        $display("[TB] FAIL reset_state: got v=%b d=%h pc=%h want v=0 d=0 pc=%h",
                 id_valid, id_data, fetch_pc, RESET_PC);
      end
    end else if (st) begin
      if (id_valid !== pre_valid || id_data !== pre_data) begin
        bad++;
        $display("[TB] FAIL stall_hold: got v=%b d=%h want v=%b d=%h",
                 id_valid, id_data, pre_valid, pre_data);
      end
    end else if (redir) begin
      exp_next = jp;
      if (id_valid !== 1'b0 || id_data[31:0] !== NOP_INSTR) begin
        bad++;
        $display("[TB] FAIL redirect_bubble: got v=%b instr=%h want v=0 instr=%h",
                 id_valid, id_data[31:0], NOP_INSTR);
      end
    end else if (id_valid === 1'b1) begin
      want = {30'(exp_next + 30'd1), rd(exp_next)};
      if (id_data !== want) begin
        bad++;
        $display("[TB] FAIL program_order: got %h want %h", id_data, want);
      end
      exp_next = 30'(exp_next + 30'd1);
      delivered++;
    end else begin
      if (id_data[31:0] !== NOP_INSTR || id_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bubble_instr: got v=%b instr=%h want v=0 instr=%h",
                 id_valid, id_data[31:0], NOP_INSTR);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    for (int i = 0; i < 8 && mem_pend; i++) step(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
    total++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      bad++;
      $display("[TB] FAIL first_req: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 30'hC00 || id_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stream_first: got req=%b addr=%h v=%b want 1 c00 0", s_req, s_addr, id_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
      total++;
      if (s_req !== 1'b1 || s_addr !== 30'(30'hC00 + i)) begin
        bad++;
        $display("[TB] FAIL stream_addr: got req=%b addr=%h want 1 %h", s_req, s_addr, 30'(30'hC00 + i));
      end
      total++;
      if (id_valid !== 1'b1 || id_data[61:32] !== 30'(30'hC00 + i)) begin
        bad++;
        $display("[TB] FAIL stream_pcp1: got v=%b pcp1=%h want 1 %h", id_valid, id_data[61:32], 30'(30'hC00 + i));
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    lat_cfg = 1;
    prog[30'hC01] = 32'h2408_0005;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 30'd0, 1'b1);
    total++;
    if (id_data[61:32] !== 30'hC01) begin
      bad++;
      $display("[TB] FAIL hold_keep: got pcp1=%h want c01", id_data[61:32]);
    end
    step(1'b0, 1'b1, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_req_stalled: got %b want 0", s_req);
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_req_release: got %b want 0", s_req);
    end
    total++;
    if (id_valid !== 1'b1 || id_data !== {30'hC02, 32'h2408_0005}) begin
      bad++;
      $display("[TB] FAIL hold_deliver: got v=%b d=%h want 1 %h", id_valid, id_data, {30'hC02, 32'h2408_0005});
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 30'hC02) begin
      bad++;
      $display("[TB] FAIL hold_reissue: got req=%b addr=%h want 1 c02", s_req, s_addr);
    end
    prog.delete(30'hC01);
  endtask

  task automatic test_redirect_kill();
    do_reset();
    lat_cfg = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    lat_cfg = 3;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_addr !== 30'hC05) begin
      bad++;
      $display("[TB] FAIL kill_setup: got addr=%h want c05", s_addr);
    end
    step(1'b0, 1'b0, 1'b1, 30'hD00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b0 || id_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL kill_drop: got req=%b v=%b want 0 0", s_req, id_valid);
    end
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 30'hD00) begin
      bad++;
      $display("[TB] FAIL kill_newaddr: got req=%b addr=%h want 1 d00", s_req, s_addr);
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (id_valid !== 1'b1 || id_data[61:32] !== 30'hD01) begin
      bad++;
      $display("[TB] FAIL kill_target: got v=%b pcp1=%h want 1 d01", id_valid, id_data[61:32]);
    end
  endtask

  task automatic test_redirect_grant();
    do_reset();
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b1, 30'h123, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 30'h123 || fetch_pc !== 30'h124) begin
      bad++;
      $display("[TB] FAIL redir_grant: got req=%b addr=%h pc=%h want 1 123 124", s_req, s_addr, fetch_pc);
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (id_valid !== 1'b1 || id_data[61:32] !== 30'h124) begin
      bad++;
      $display("[TB] FAIL redir_grant_deliver: got v=%b pcp1=%h want 1 124", id_valid, id_data[61:32]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
    total++;
    if (fetch_pc !== 30'd0) begin
      bad++;
      $display("[TB] FAIL wrap_pc: got %h want 0", fetch_pc);
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 30'd0 || id_valid !== 1'b1 || id_data[61:32] !== 30'd0) begin
      bad++;
      $display("[TB] FAIL wrap_next: got req=%b addr=%h v=%b pcp1=%h want 1 0 1 0",
               s_req, s_addr, id_valid, id_data[61:32]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_cfg = 3;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      bad++;
      $display("[TB] FAIL rst_mid_addr: got req=%b addr=%h want 1 %h", s_req, s_addr, RESET_PC);
    end
    lat_cfg = 1;
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (id_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_stale: got v=%b want 0", id_valid);
    end
    step(1'b0, 1'b0, 1'b0, 30'd0, 1'b1);
    total++;
    if (id_valid !== 1'b1 || id_data[61:32] !== 30'hC01) begin
      bad++;
      $display("[TB] FAIL rst_mid_first: got v=%b pcp1=%h want 1 c01", id_valid, id_data[61:32]);
    end
  endtask

  task automatic test_random();
    logic [29:0] jp;
    do_reset();
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      lat_cfg = int'($urandom_range(1, 4));
      jp = ($urandom % 4 == 0) ? 30'(30'h3FFF_FFFE + 30'($urandom % 2)) : 30'($urandom);
      step(($urandom % 400) == 0, ($urandom % 100) < 20, ($urandom % 100) < 10, jp,
           ($urandom % 100) < 70);
    end
    total++;
    if (delivered <= 100) begin
      bad++;
      $display("[TB] FAIL random_progress: got %0d instrs want >100", delivered);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jpc_avail = 1'b0; jpc = '0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    mem_pend = 1'b0; mem_addr = '0; mem_cnt = 0; lat_cfg = 1;
    exp_next = RESET_PC; delivered = 0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_kill();
    test_redirect_grant();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
